// File: rtl/return_addr_stack_pkg.sv
// Shared definitions for the return address stack.
//   ras_checkpoint_t : {ptr, count, top_cnt} snapshot taken at fetch and
//                      handed back by the branch unit on a mispredict.
//   RAS_DEPTH / RAS_CNT_WIDTH : default stack depth and recursion counter width.
//   `ADDR_WIDTH : default return address width (32 unless defined earlier).
// The checkpoint fields are sized for RAS_DEPTH; smaller stacks zero-extend.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package return_addr_stack_pkg;

    localparam int RAS_DEPTH     = 8;
    localparam int RAS_CNT_WIDTH = 2;
    localparam int RAS_PTR_WIDTH = $clog2(RAS_DEPTH);
    localparam int RAS_CNT_FIELD = RAS_PTR_WIDTH + 1;

    typedef struct packed {
        logic [RAS_PTR_WIDTH-1:0] ptr;
        logic [RAS_CNT_FIELD-1:0] count;
        logic [RAS_CNT_WIDTH-1:0] top_cnt;
    } ras_checkpoint_t;

    localparam int RAS_CP_WIDTH = $bits(ras_checkpoint_t);

endpackage

// File: rtl/return_addr_stack.sv
// Return address stack for the branch predictor.
// Calls push, returns pop, push+pop together replaces the top entry.
// A push on a full stack silently overwrites the oldest entry (circular).
// A mispredict restore reloads ptr/count from a checkpoint and wins over
// push/pop in the same cycle; overwritten entries are not repaired.
// Optional feature: define RAS_RECURSION_COUNTER_EN to add a per-entry
// recursion counter so repeated pushes of the same address share one entry.
// Ports:
//   clk, rst                 clock, async active-high reset
//   bp_ras_addr/push/pop     predictor request
//   ras_bp_addr              current top entry (combinational)
//   ras_bp_empty/full        valid count is 0 / DEPTH
//   ras_bp_cp                checkpoint {ptr, count, top_cnt}
//   exbru_ras_restore_valid  restore request
//   exbru_ras_restore_cp     checkpoint to restore
module return_addr_stack
    import return_addr_stack_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int CNT_WIDTH  = RAS_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   bp_ras_addr,
    input  logic                    bp_ras_push,
    input  logic                    bp_ras_pop,
    output logic [ADDR_WIDTH-1:0]   ras_bp_addr,
    output logic                    ras_bp_empty,
    output logic                    ras_bp_full,
    output logic [RAS_CP_WIDTH-1:0] ras_bp_cp,
    input  logic                    exbru_ras_restore_valid,
    input  logic [RAS_CP_WIDTH-1:0] exbru_ras_restore_cp
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_W     = PTR_WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] entries [DEPTH];
    logic [PTR_WIDTH-1:0]  ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_WIDTH-1:0]  top_cnt;

    logic [PTR_WIDTH-1:0]  ptr_inc;
    logic [PTR_WIDTH-1:0]  ptr_dec;
    ras_checkpoint_t       cp_in;
    ras_checkpoint_t       cp_out;
    logic [PTR_WIDTH-1:0]  cp_ptr;
    logic [CNT_W-1:0]      cp_count;
    logic                  push_only;
    logic                  pop_only;
    logic                  do_replace;
    logic                  do_push;
    logic                  do_pop;
    logic                  do_inc;
    logic                  do_dec;
    logic                  unused_cp;

    assign cp_in     = ras_checkpoint_t'(exbru_ras_restore_cp);
    assign cp_ptr    = PTR_WIDTH'(cp_in.ptr);
    assign cp_count  = CNT_W'(cp_in.count);
    // Upper checkpoint bits are unused for stacks smaller than RAS_DEPTH.
    assign unused_cp = ^exbru_ras_restore_cp;

    always_comb begin
        ptr_inc    = ptr + 1'b1;
        ptr_dec    = ptr - 1'b1;
        do_replace = !exbru_ras_restore_valid && bp_ras_push && bp_ras_pop;
        push_only  = !exbru_ras_restore_valid && bp_ras_push && !bp_ras_pop;
        pop_only   = !exbru_ras_restore_valid && bp_ras_pop && !bp_ras_push
                     && (count != '0);
        do_inc     = 1'b0;
        do_dec     = 1'b0;
`ifdef RAS_RECURSION_COUNTER_EN
        // Recursive call to the same site: bump the counter, keep the entry.
        do_inc = push_only && (count != '0) && (entries[ptr] == bp_ras_addr)
                 && !(&top_cnt);
        do_dec = pop_only && (top_cnt != '0);
`endif
        do_push = push_only && !do_inc;
        do_pop  = pop_only && !do_dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (exbru_ras_restore_valid) begin
            ptr   <= cp_ptr;
            count <= cp_count;
        end else if (do_replace) begin
            entries[ptr] <= bp_ras_addr;
            if (count == '0) begin
                count <= CNT_W'(1);
            end
        end else if (do_push) begin
            ptr              <= ptr_inc;
            entries[ptr_inc] <= bp_ras_addr;
            if (count != FULL_CNT) begin
                count <= count + 1'b1;
            end
        end else if (do_pop) begin
            ptr   <= ptr_dec;
            count <= count - 1'b1;
        end
    end

`ifdef RAS_RECURSION_COUNTER_EN
    logic [CNT_WIDTH-1:0] rcnt [DEPTH];

    assign top_cnt = rcnt[ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rcnt[i] <= '0;
            end
        end else if (exbru_ras_restore_valid) begin
            rcnt[cp_ptr] <= CNT_WIDTH'(cp_in.top_cnt);
        end else if (do_replace) begin
            rcnt[ptr] <= '0;
        end else if (do_push) begin
            rcnt[ptr_inc] <= '0;
        end else if (do_inc) begin
            rcnt[ptr] <= top_cnt + 1'b1;
        end else if (do_dec) begin
            rcnt[ptr] <= top_cnt - 1'b1;
        end
    end
`else
    assign top_cnt = '0;
`endif

    always_comb begin
        cp_out         = '0;
        cp_out.ptr     = RAS_PTR_WIDTH'(ptr);
        cp_out.count   = RAS_CNT_FIELD'(count);
        cp_out.top_cnt = RAS_CNT_WIDTH'(top_cnt);
    end

    assign ras_bp_addr  = entries[ptr];
    assign ras_bp_empty = (count == '0);
    assign ras_bp_full  = (count == FULL_CNT);
    assign ras_bp_cp    = cp_out;

endmodule

// File: tb/tb_return_addr_stack.sv
module tb_return_addr_stack;
    import return_addr_stack_pkg::*;

    localparam int D = 4;
`ifdef RAS_RECURSION_COUNTER_EN
    localparam bit RC_EN = 1'b1;
`else
    localparam bit RC_EN = 1'b0;
`endif
    localparam int MAXRC = (1 << RAS_CNT_WIDTH) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [31:0]             bp_ras_addr;
    logic                    bp_ras_push;
    logic                    bp_ras_pop;
    logic [31:0]             ras_bp_addr;
    logic                    ras_bp_empty;
    logic                    ras_bp_full;
    logic [RAS_CP_WIDTH-1:0] ras_bp_cp;
    logic                    exbru_ras_restore_valid;
    logic [RAS_CP_WIDTH-1:0] exbru_ras_restore_cp;

    int n_vec = 0;
    int n_bad = 0;

    return_addr_stack #(.DEPTH(D), .ADDR_WIDTH(32)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .bp_ras_addr             (bp_ras_addr),
        .bp_ras_push             (bp_ras_push),
        .bp_ras_pop              (bp_ras_pop),
        .ras_bp_addr             (ras_bp_addr),
        .ras_bp_empty            (ras_bp_empty),
        .ras_bp_full             (ras_bp_full),
        .ras_bp_cp               (ras_bp_cp),
        .exbru_ras_restore_valid (exbru_ras_restore_valid),
        .exbru_ras_restore_cp    (exbru_ras_restore_cp)
    );

    always #5 clk = ~clk;

    function automatic logic [RAS_CP_WIDTH-1:0] mk_cp(int p, int c, int t);
        ras_checkpoint_t x;
        x.ptr     = RAS_PTR_WIDTH'(p);
        x.count   = RAS_CNT_FIELD'(c);
        x.top_cnt = RAS_CNT_WIDTH'(t);
        return x;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string nm, input logic [31:0] a, input int p,
                             input int c, input int t);
        chk({nm, ".addr"},  64'(ras_bp_addr),  64'(a));
        chk({nm, ".empty"}, 64'(ras_bp_empty), 64'(c == 0));
        chk({nm, ".full"},  64'(ras_bp_full),  64'(c == D));
        chk({nm, ".cp"},    64'(ras_bp_cp),    64'(mk_cp(p, c, t)));
    endtask

    task automatic drive(input bit pu, input bit po, input logic [31:0] a,
                         input bit rs, input logic [RAS_CP_WIDTH-1:0] cp);
        bp_ras_push             = pu;
        bp_ras_pop              = po;
        bp_ras_addr             = a;
        exbru_ras_restore_valid = rs;
        exbru_ras_restore_cp    = cp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge; finishes well before the next one.
    task automatic do_reset();
        drive(0, 0, 32'h0, 0, '0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // Reference model: the stack as a circular array of DEPTH slots with a
    // top index and a valid count, updated straight from the call/return rules.
    logic [31:0] m_ent [D];
    int          m_rc  [D];
    int          m_ptr, m_cnt;

    function automatic void model_reset();
        for (int i = 0; i < D; i++) begin
            m_ent[i] = 32'h0;
            m_rc[i]  = 0;
        end
        m_ptr = 0;
        m_cnt = 0;
    endfunction

    function automatic void model_step(bit pu, bit po, logic [31:0] a, bit rs,
                                       int rp, int rc, int rt);
        if (rs) begin
            m_ptr     = rp;
            m_cnt     = rc;
            m_rc[rp]  = RC_EN ? rt : 0;
        end else if (pu && po) begin
            m_ent[m_ptr] = a;
            m_rc[m_ptr]  = 0;
            if (m_cnt == 0) m_cnt = 1;
        end else if (pu) begin
            if (RC_EN && m_cnt > 0 && m_ent[m_ptr] == a && m_rc[m_ptr] < MAXRC) begin
                m_rc[m_ptr] = m_rc[m_ptr] + 1;
            end else begin
                m_ptr        = (m_ptr + 1) % D;
                m_ent[m_ptr] = a;
                m_rc[m_ptr]  = 0;
                if (m_cnt < D) m_cnt = m_cnt + 1;
            end
        end else if (po && m_cnt > 0) begin
            if (RC_EN && m_rc[m_ptr] > 0) begin
                m_rc[m_ptr] = m_rc[m_ptr] - 1;
            end else begin
                m_ptr = (m_ptr + D - 1) % D;
                m_cnt = m_cnt - 1;
            end
        end
    endfunction

    typedef struct {
        bit          push;
        bit          pop;
        logic [31:0] addr;
        logic [31:0] e_addr;
        int          e_ptr;
        int          e_cnt;
    } vec_t;

    vec_t vt [13];

    int hp [8];
    int hc [8];
    int ht [8];

    initial begin
        logic [RAS_CP_WIDTH-1:0] cap;

        rst = 1'b1;
        drive(0, 0, 32'h0, 0, '0);
        repeat (2) tick();
        drive(1, 1, 32'hdead_beef, 1, mk_cp(2, 3, 1));
        tick();
        chk_state("rst_held", 32'h0, 0, 0, 0);
        drive(0, 0, 32'h0, 0, '0);
        rst = 1'b0;
        #1;
        chk_state("rst_release", 32'h0, 0, 0, 0);
        tick();

        // Fill past full, drain past empty, then replace on an empty stack.
        vt[0]  = '{1, 0, 32'h10, 32'h10, 1, 1};
        vt[1]  = '{1, 0, 32'h20, 32'h20, 2, 2};
        vt[2]  = '{1, 0, 32'h30, 32'h30, 3, 3};
        vt[3]  = '{1, 0, 32'h40, 32'h40, 0, 4};
        vt[4]  = '{1, 0, 32'h50, 32'h50, 1, 4};
        vt[5]  = '{0, 1, 32'h0,  32'h40, 0, 3};
        vt[6]  = '{0, 1, 32'h0,  32'h30, 3, 2};
        vt[7]  = '{0, 1, 32'h0,  32'h20, 2, 1};
        vt[8]  = '{0, 1, 32'h0,  32'h50, 1, 0};
        vt[9]  = '{0, 1, 32'h0,  32'h50, 1, 0};
        vt[10] = '{0, 0, 32'h0,  32'h50, 1, 0};
        vt[11] = '{1, 1, 32'h77, 32'h77, 1, 1};
        vt[12] = '{1, 1, 32'h88, 32'h88, 1, 1};
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].push, vt[i].pop, vt[i].addr, 0, '0);
            tick();
            chk_state($sformatf("table[%0d]", i), vt[i].e_addr, vt[i].e_ptr, vt[i].e_cnt, 0);
        end

        // Async reset in the middle of a cycle clears state with no clock.
        drive(0, 0, 32'h0, 0, '0);
        #1;
        rst = 1'b1;
        #1;
        chk_state("async_rst", 32'h0, 0, 0, 0);
        drive(1, 0, 32'h55, 0, '0);
        tick();
        chk_state("rst_push_ignored", 32'h0, 0, 0, 0);
        drive(0, 0, 32'h0, 0, '0);
        rst = 1'b0;
        tick();

        // Push two, pop: old top visible during the pop cycle.
        drive(1, 0, 32'h8010_0024, 0, '0); tick();
        drive(1, 0, 32'h8010_0100, 0, '0); tick();
        drive(0, 1, 32'h0, 0, '0);
        #1;
        chk("pop_cycle.addr", 64'(ras_bp_addr), 64'h8010_0100);
        tick();
        chk_state("after_pop", 32'h8010_0024, 1, 1, 0);

        // Replace keeps ptr and count.
        do_reset();
        tick();
        drive(1, 0, 32'h8010_0024, 0, '0); tick();
        drive(1, 1, 32'h80aa_bbc0, 0, '0); tick();
        chk_state("replace", 32'h80aa_bbc0, 1, 1, 0);

        // Checkpoint after 0xA0, push more, restore beats a same-cycle push.
        do_reset();
        tick();
        drive(1, 0, 32'hA0, 0, '0); tick();
        cap = ras_bp_cp;
        chk("cp_capture", 64'(cap), 64'(mk_cp(1, 1, 0)));
        drive(1, 0, 32'hB0, 0, '0); tick();
        drive(1, 0, 32'hC0, 0, '0); tick();
        chk_state("pre_restore", 32'hC0, 3, 3, 0);
        drive(1, 0, 32'hD0, 1, cap); tick();
        chk_state("restore", 32'hA0, 1, 1, 0);

`ifdef RAS_RECURSION_COUNTER_EN
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h80, 0, '0);
            tick();
        end
        chk_state("recur_push", 32'h80, 1, 1, 2);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'h0, 0, '0);
            #1;
            chk($sformatf("recur_pop[%0d]", i), 64'(ras_bp_addr), 64'h80);
            tick();
        end
        chk("recur_empty", 64'(ras_bp_empty), 64'h1);
`endif

        // Randomized traffic against the model.
        do_reset();
        model_reset();
        for (int i = 0; i < 8; i++) begin
            hp[i] = 0; hc[i] = 0; ht[i] = 0;
        end
        tick();
        for (int i = 0; i < 400; i++) begin
            int          r, k;
            bit          pu, po, rs;
            logic [31:0] a;
            hp[i % 8] = m_ptr;
            hc[i % 8] = m_cnt;
            ht[i % 8] = m_rc[m_ptr];
            r  = int'($urandom_range(0, 99));
            pu = (r < 45) || (r >= 85 && r < 92);
            po = (r >= 45 && r < 85) || (r >= 85 && r < 92);
            rs = ($urandom_range(0, 99) < 8);
            a  = 32'(($urandom_range(0, 3) + 1) * 16);
            k  = int'($urandom_range(0, 7));
            drive(pu, po, a, rs, mk_cp(hp[k], hc[k], ht[k]));
            model_step(pu, po, a, rs, hp[k], hc[k], ht[k]);
            tick();
            chk_state($sformatf("rand[%0d]", i), m_ent[m_ptr], m_ptr, m_cnt, m_rc[m_ptr]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/return_addr_stack.md
RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of stack entries; power of two, at least 2.
REQ-002 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH (32), width of one return address.
REQ-003 SHALL have parameter CNT_WIDTH, default 2, width of the per-entry recursion counter; used only when RAS_RECURSION_COUNTER_EN is defined.
REQ-004 SHALL define PTR_WIDTH as $clog2(DEPTH) and derive it internally.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 bp_ras_addr  input  ADDR_WIDTH  return address to push.
REQ-009 bp_ras_push  input  1  push request (call).
REQ-010 bp_ras_pop  input  1  pop request (return); push and pop together form a replace (context switch).
REQ-011 ras_bp_addr  output  ADDR_WIDTH  current top entry, combinational from state.
REQ-012 ras_bp_empty  output  1  high when the valid count is 0.
REQ-013 ras_bp_full  output  1  high when the valid count is DEPTH.
REQ-014 ras_bp_cp  output  $bits(ras_checkpoint_t)  current {ptr, count, top_cnt}, captured by fetch for later restore.
REQ-015 exbru_ras_restore_valid  input  1  mispredict restore request.
REQ-016 exbru_ras_restore_cp  input  $bits(ras_checkpoint_t)  checkpoint to restore.

Function
REQ-017 SHALL hold entry[0..DEPTH-1], top pointer ptr (PTR_WIDTH bits) and valid count (0..DEPTH, PTR_WIDTH+1 bits).
REQ-018 ras_bp_addr SHALL equal entry[ptr] in the same cycle, before any update at the clock edge.
REQ-019 Push only: ptr <= ptr+1 modulo DEPTH; entry[ptr+1] <= bp_ras_addr; count <= min(count+1, DEPTH).
REQ-020 Push when full SHALL overwrite the oldest entry without stalling; count stays DEPTH.
REQ-021 Pop only with count > 0: ptr <= ptr-1 modulo DEPTH; count <= count-1. Entry contents are not cleared.
REQ-022 Pop only with count = 0 SHALL be ignored: no state change.
REQ-023 Push and pop together SHALL set entry[ptr] <= bp_ras_addr, leave ptr unchanged, and set count <= max(count, 1).
REQ-024 exbru_ras_restore_valid SHALL take priority over push and pop in the same cycle: ptr and count load from the checkpoint, and push/pop are dropped.
REQ-025 Restore SHALL NOT repair entries overwritten after the checkpoint was taken.
REQ-026 Every state change SHALL be visible on the outputs the cycle after the edge (latency 1).

Reset
REQ-027 On rst assertion, ptr, count, all entries and all counters SHALL clear to 0 immediately, regardless of clock.
REQ-028 While rst is high: ras_bp_addr = 0, ras_bp_empty = 1, ras_bp_full = 0, ras_bp_cp = 0; push, pop and restore are ignored.
REQ-029 Reset asserted mid-sequence SHALL discard all pending state; there is no partial retention.

Configuration
REQ-030 Macro RAS_RECURSION_COUNTER_EN SHALL enable recursion compression, with one CNT_WIDTH counter per entry.
REQ-031 With the macro defined:
- A push whose address equals entry[ptr], with count > 0 and counter not saturated, SHALL increment cnt[ptr] only.
- A pop with cnt[ptr] > 0 SHALL decrement cnt[ptr] only.
- A new push SHALL clear cnt of the written entry.
- A replace SHALL clear cnt[ptr].
- Restore SHALL load cnt[restored ptr] from top_cnt.
REQ-032 Without the macro, no counters exist, the top_cnt field is tied 0, and behaviour follows REQ-019..REQ-025 exactly.

Structure
REQ-033 ras_checkpoint_t (ptr, count, top_cnt) SHALL live in the shared common package; RAS_DEPTH and RAS_CNT_WIDTH defaults SHALL live in config.
REQ-034 The block SHALL be a single module with no sub-module; storage is an inline register array, since the combinational top read precludes a synchronous RAM.

Verification (DEPTH=4, macro off unless stated)
REQ-035 Release reset -> ras_bp_addr=0, empty=1, full=0, ras_bp_cp=0.
REQ-036 Push 0x80100024, push 0x80100100, then pop -> ras_bp_addr=0x80100100 during the pop cycle, 0x80100024 the next cycle, count=1.
REQ-037 Push 0x10, 0x20, 0x30, 0x40, 0x50 -> full=1 after the 4th push; subsequent pops return 0x50, 0x40, 0x30, 0x20, then empty=1 and a further pop changes nothing.
REQ-038 With top=0x80100024, push and pop together with 0x80aabbc0 -> top=0x80aabbc0, ptr and count unchanged.
REQ-039 Capture ras_bp_cp after push 0xA0; push 0xB0 and 0xC0; then restore in the same cycle as push 0xD0 -> top=0xA0, count=1, 0xD0 not pushed.
REQ-040 With the macro defined, push 0x80 three times -> ptr unchanged and cnt=2; three pops each return 0x80, after which empty=1.
